// File: rtl/trace_pkg.sv
// Shared trace capture types: FSM encoding, flag bit positions, entry layout.
package trace_pkg;

  localparam int FLAG_W     = 5;
  localparam int FLG_AUX    = 0;
  localparam int FLG_CARRY  = 1;
  localparam int FLG_SIGN   = 2;
  localparam int FLG_ZERO   = 3;
  localparam int FLG_PARITY = 4;

  localparam int TRACE_DATA_W  = 32;
  localparam int TRACE_STAMP_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } trace_state_t;

  // Entry layout at default widths; the top packs the same field order.
  typedef struct packed {
    logic [TRACE_DATA_W-1:0]  data;
    logic [FLAG_W-1:0]        flags;
    logic [TRACE_STAMP_W-1:0] stamp;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace buffer storage: one write port, one registered read port.
module trace_ram
  import trace_pkg::*;
#(
  parameter int WIDTH = TRACE_DATA_W + FLAG_W + TRACE_STAMP_W,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value until the next pop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_capture_unit.sv
// Execution trace capture FIFO with stop/overwrite policy and timestamps.
// Optional TRACE_CHANGE_ONLY_EN: push only when {result, flags} changes.
module trace_capture_unit
  import trace_pkg::*;
#(
  parameter int DATA_WIDTH = TRACE_DATA_W,
  parameter int DEPTH      = 16,
  parameter int STAMP_W    = TRACE_STAMP_W,
  parameter int WRAP_MODE  = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cap_en,
  input  logic                    cap_valid,
  input  logic [DATA_WIDTH-1:0]   result,
  input  logic [FLAG_W-1:0]       flags,
  input  logic                    rd_req,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [FLAG_W-1:0]       rd_flags,
  output logic [STAMP_W-1:0]      rd_stamp,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic [7:0]              ovf_cnt,
  output logic [1:0]              state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + FLAG_W + STAMP_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic WRAP = (WRAP_MODE != 0);

  trace_state_t cur_state, nxt_state;

  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      cnt;
  logic [STAMP_W-1:0] stamp;
  logic [7:0]         ovf;
  logic               rd_vld;

  logic is_full, is_empty;
  logic pop, push_try, chg_ok;
  logic do_wr, drop, ovwr;
  logic inc, dec;

  logic [EW-1:0] wr_ent, rd_ent;

  assign is_full  = (cnt == FULL_CNT);
  assign is_empty = (cnt == '0);
  assign pop      = rd_req && !is_empty;
  assign push_try = (cur_state == RUN) && cap_valid && chg_ok;

  assign do_wr = push_try && (!is_full || pop || WRAP);
  assign drop  = push_try && is_full && !pop && !WRAP;
  assign ovwr  = push_try && is_full && !pop && WRAP;

  assign inc = do_wr && !pop && !ovwr;
  assign dec = pop && !do_wr;

  assign wr_ent = {result, flags, stamp};

`ifdef TRACE_CHANGE_ONLY_EN
  logic [DATA_WIDTH+FLAG_W-1:0] last_val;
  logic                         have_last;

  // Idle forgets the history so a fresh capture always records first value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      have_last <= 1'b0;
      last_val  <= '0;
    end else if (cur_state == IDLE) begin
      have_last <= 1'b0;
    end else if (push_try) begin
      have_last <= 1'b1;
      last_val  <= {result, flags};
    end
  end

  assign chg_ok = !have_last || ({result, flags} != last_val);
`else
  assign chg_ok = 1'b1;
`endif

  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      IDLE: if (cap_en) nxt_state = RUN;
      RUN: begin
        if (!cap_en)   nxt_state = IDLE;
        else if (drop) nxt_state = STOP;
      end
      STOP: begin
        if (!cap_en)              nxt_state = IDLE;
        else if (cnt < FULL_CNT)  nxt_state = RUN;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cur_state <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      stamp     <= '0;
      ovf       <= '0;
      rd_vld    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      stamp     <= stamp + STAMP_W'(1);
      rd_vld    <= pop;
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop || ovwr) rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        inc:     cnt <= cnt + CW'(1);
        dec:     cnt <= cnt - CW'(1);
        default: ;
      endcase
      if ((drop || ovwr) && ovf != 8'hFF) ovf <= ovf + 8'd1;
    end
  end

  trace_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .CLK   (CLK),
    .RST   (RST),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata (wr_ent),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (rd_ent)
  );

  assign {rd_data, rd_flags, rd_stamp} = rd_ent;

  assign rd_valid = rd_vld;
  assign count    = cnt;
  assign full     = is_full;
  assign empty    = is_empty;
  assign ovf_cnt  = ovf;
  assign state    = cur_state;

endmodule

// File: doc/trace_capture_unit.md
TRACE_CAPTURE_UNIT -- requirements
Module: trace_capture_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of captured execution result.
REQ-002 SHALL have parameter DEPTH, default 16, trace buffer entries (power of two, 2..256).
REQ-003 SHALL have parameter STAMP_W, default 16, timestamp width.
REQ-004 SHALL have parameter WRAP_MODE, default 0; 0 = stop-when-full, 1 = overwrite-oldest.
REQ-005 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port cap_en  input  1  arms capture while high.
REQ-008 SHALL have port cap_valid  input  1  result/flags valid this cycle.
REQ-009 SHALL have port result  input  DATA_WIDTH  execution result.
REQ-010 SHALL have port flags  input  5  {parity, zero, sign, carry, auxiliary}.
REQ-011 SHALL have port rd_req  input  1  pop request for the oldest entry.
REQ-012 SHALL have port rd_valid  output  1  rd_* fields valid, one-cycle pulse.
REQ-013 SHALL have ports rd_data (DATA_WIDTH), rd_flags (5) and rd_stamp (STAMP_W)  outputs  popped entry.
REQ-014 SHALL have ports count (clog2(DEPTH)+1), full (1) and empty (1)  outputs  occupancy.
REQ-015 SHALL have port ovf_cnt  output  8  saturating count of dropped or overwritten entries.
REQ-016 SHALL have port state  output  2  FSM state: IDLE=0, RUN=1, STOP=2.

Function
REQ-017 SHALL keep a free-running STAMP_W cycle counter that starts at 0 after reset and wraps modulo 2^STAMP_W.
REQ-018 SHALL transition IDLE->RUN when cap_en=1, RUN->IDLE when cap_en=0, RUN->STOP when WRAP_MODE=0 and a push is attempted while full, STOP->RUN when count<DEPTH and cap_en=1, and STOP->IDLE when cap_en=0.
REQ-019 SHALL push {result, flags, timestamp-of-this-cycle} only in state RUN with cap_valid=1; pushes are visible in count on the next cycle.
REQ-020 SHALL, when rd_req=1 and empty=0, assert rd_valid with the oldest entry on the next cycle (latency 1); rd_req while empty SHALL be ignored and SHALL NOT assert rd_valid.
REQ-021 SHALL, on a simultaneous push and pop, perform both in the same cycle, leave count unchanged, and count no overflow, even when full.
REQ-022 SHALL, in WRAP_MODE=1 with a push while full and no pop, overwrite the oldest entry, advance the read pointer, and increment ovf_cnt.
REQ-023 SHALL, in WRAP_MODE=0 with a push while full and no pop, drop the push, increment ovf_cnt, and enter STOP.
REQ-024 SHALL saturate ovf_cnt at 255.
REQ-025 SHALL wrap read and write pointers modulo DEPTH, with full = (count==DEPTH) and empty = (count==0).
REQ-026 SHALL hold rd_data, rd_flags and rd_stamp stable between pops.

Reset
REQ-027 SHALL, while RST=0, force state=IDLE, count=0, empty=1, full=0, rd_valid=0, rd_data=0, rd_flags=0, rd_stamp=0, ovf_cnt=0, the timestamp to 0, and both pointers to 0, independent of CLK.
REQ-028 SHALL, on reset asserted mid-capture, discard all buffered entries; the buffer array itself need not be cleared.

Configuration
REQ-029 SHALL, with TRACE_CHANGE_ONLY_EN defined, qualify each push with "{result, flags} differs from the last pushed value"; the first push after reset or after leaving IDLE is always accepted. Without the macro, every qualifying cap_valid cycle pushes.

Structure
REQ-030 SHALL place the state encoding, the flag bit-index constants, and the trace-entry packed typedef in shared package trace_pkg.
REQ-031 SHALL implement storage as one sub-module, trace_ram: DEPTH x entry-width, one write port and one registered read port.

Verification
REQ-032 SHALL cover: DEPTH=4, WRAP_MODE=0, 5 pushes of result 1..5 -> count=4, full=1, ovf_cnt=1, state=STOP; 4 pops return 1,2,3,4 with increasing rd_stamp.
REQ-033 SHALL cover: DEPTH=4, WRAP_MODE=1, 6 pushes of 1..6 -> pops return 3,4,5,6; ovf_cnt=2; state stays RUN.
REQ-034 SHALL cover: full buffer, push 9 and pop on the same cycle -> rd_data = oldest entry, count stays 4, ovf_cnt unchanged.
REQ-035 SHALL cover: rd_req while empty -> rd_valid stays 0 and all outputs are unchanged.
REQ-036 SHALL cover: RST pulled low between clock edges after 3 pushes -> count=0, empty=1, state=IDLE immediately; the timestamp restarts at 0.
REQ-037 SHALL cover, with TRACE_CHANGE_ONLY_EN: result 7,7,7,8 pushed with constant flags -> count=2, pops return 7 then 8.
